// File: rtl/gpr_pkg.sv
// gpr_pkg: shared defaults and types for the gpr_sb register file and scoreboard
package gpr_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW = $clog2(NREG_DEF);
  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xword_t;
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register pending bits; ports i_we/i_waddr clear, i_rsv_en/i_rsv_addr set, i_flush clears all, o_busy is the pending vector
module gpr_scoreboard import gpr_pkg::*; #(
  parameter int NREG = NREG_DEF,
  parameter int NWRITE = 2,
  localparam int IW = $clog2(NREG)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NWRITE-1:0]    i_we,
  input  logic [NWRITE*IW-1:0] i_waddr,
  input  logic [NWRITE-1:0]    i_rsv_en,
  input  logic [NWRITE*IW-1:0] i_rsv_addr,
  input  logic                 i_flush,
  output logic [NREG-1:0]      o_busy
);
  logic [NREG-1:0] r_pend, w_set, w_clr, w_nxt;
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int j = 0; j < NWRITE; j++) begin
      if (i_rsv_en[j]) w_set[i_rsv_addr[j*IW +: IW]] = 1'b1;
      if (i_we[j]) w_clr[i_waddr[j*IW +: IW]] = 1'b1;
    end
    // a new reservation beats both flush and a same-cycle completion
    w_nxt = w_set | (i_flush ? '0 : r_pend & ~w_clr);
    w_nxt[0] = 1'b0;
  end
  always_ff @(posedge i_clk) begin
    r_pend <= !i_rst_n ? '0 : w_nxt;
  end
  assign o_busy = r_pend;
endmodule

// File: rtl/gpr_sb.sv
// gpr_sb: register file with write-through forwarding and scoreboard; i_raddr->o_rdata/o_rready reads, i_we/i_waddr/i_wdata write-back, i_rsv_en/i_rsv_addr reserve, i_flush, o_busy pending vector
module gpr_sb import gpr_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NREAD = 4,
  parameter int NWRITE = 2,
  localparam int IW = $clog2(NREG)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NREAD*IW-1:0]    i_raddr,
  output logic [NREAD*XLEN-1:0]  o_rdata,
  output logic [NREAD-1:0]       o_rready,
  input  logic [NWRITE-1:0]      i_we,
  input  logic [NWRITE*IW-1:0]   i_waddr,
  input  logic [NWRITE*XLEN-1:0] i_wdata,
  input  logic [NWRITE-1:0]      i_rsv_en,
  input  logic [NWRITE*IW-1:0]   i_rsv_addr,
  input  logic                   i_flush,
  output logic [NREG-1:0]        o_busy
);
  // entry 0 is never written, so it stays at its reset value and folds away
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] w_pend;
  gpr_scoreboard #(.NREG(NREG), .NWRITE(NWRITE)) u_sb (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_we(i_we),
    .i_waddr(i_waddr),
    .i_rsv_en(i_rsv_en),
    .i_rsv_addr(i_rsv_addr),
    .i_flush(i_flush),
    .o_busy(w_pend)
  );
  assign o_busy = w_pend;
  // ascending port order: the last nonblocking write (highest port) wins a collision
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++)
        if (i_we[j] && i_waddr[j*IW +: IW] != '0) r_regs[i_waddr[j*IW +: IW]] <= i_wdata[j*XLEN +: XLEN];
    end
  end
  always_comb begin
    o_rdata = '0;
    o_rready = '0;
    for (int i = 0; i < NREAD; i++) begin
      o_rdata[i*XLEN +: XLEN] = r_regs[i_raddr[i*IW +: IW]];
      o_rready[i] = !w_pend[i_raddr[i*IW +: IW]];
      for (int j = 0; j < NWRITE; j++)
        if (i_we[j] && i_waddr[j*IW +: IW] == i_raddr[i*IW +: IW]) begin
          o_rdata[i*XLEN +: XLEN] = i_wdata[j*XLEN +: XLEN];
          o_rready[i] = 1'b1;
        end
      if (i_raddr[i*IW +: IW] == '0) begin
        o_rdata[i*XLEN +: XLEN] = '0;
        o_rready[i] = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gpr_sb.sv
// tb_gpr_sb: directed and random checks of gpr_sb against a behavioural register/scoreboard model
module tb_gpr_sb;
  import gpr_pkg::*;
  localparam int NR = 4, NW = 2, X = 32, N = 32, A = 5;
  logic clk = 0, rst_n;
  logic [NR*A-1:0] raddr;
  logic [NR*X-1:0] rdata;
  logic [NR-1:0] rready;
  logic [NW-1:0] we, rsv_en;
  logic [NW*A-1:0] waddr, rsv_addr;
  logic [NW*X-1:0] wdata;
  logic flush;
  logic [N-1:0] busy;
  int errors = 0, checks = 0;
  logic [X-1:0] m_regs [N];
  bit m_pend [N];
  always #5 clk = ~clk;
  gpr_sb dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata), .o_rready(rready),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
    .i_flush(flush), .o_busy(busy)
  );
  task automatic chk(input string tag, input logic [X-1:0] got, input logic [X-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic void m_read(input logic [A-1:0] a, output logic [X-1:0] d, output logic r);
    d = m_regs[a];
    r = !m_pend[a];
    for (int j = NW - 1; j >= 0; j--)
      if (we[j] && waddr[j*A +: A] == a) begin
        d = wdata[j*X +: X];
        r = 1'b1;
        break;
      end
    if (a == 0) begin
      d = '0;
      r = 1'b1;
    end
  endfunction
  task automatic mid();
    logic [X-1:0] d;
    logic r;
    logic [N-1:0] eb;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      m_read(raddr[i*A +: A], d, r);
      chk($sformatf("rdata%0d", i), rdata[i*X +: X], d);
      chk($sformatf("rready%0d", i), {31'b0, rready[i]}, {31'b0, r});
    end
    eb = '0;
    for (int k = 1; k < N; k++) eb[k] = m_pend[k];
    chk("busy", busy, eb);
  endtask
  task automatic fin();
    bit np [N];
    bit s, c;
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_regs[k] = '0;
        m_pend[k] = 0;
      end
    end else begin
      for (int k = 1; k < N; k++) begin
        s = 0;
        c = 0;
        for (int j = 0; j < NW; j++) begin
          if (rsv_en[j] && rsv_addr[j*A +: A] == k) s = 1;
          if (we[j] && waddr[j*A +: A] == k) c = 1;
        end
        np[k] = s ? 1'b1 : flush ? 1'b0 : c ? 1'b0 : m_pend[k];
      end
      for (int k = 1; k < N; k++) m_pend[k] = np[k];
      for (int j = 0; j < NW; j++)
        if (we[j] && waddr[j*A +: A] != 0) m_regs[waddr[j*A +: A]] = wdata[j*X +: X];
    end
    #1;
  endtask
  task automatic step();
    mid();
    fin();
  endtask
  task automatic idle();
    we = '0;
    rsv_en = '0;
    flush = 0;
  endtask
  task automatic rnd_in(input int amax);
    we = NW'($urandom);
    rsv_en = NW'($urandom);
    for (int j = 0; j < NW; j++) begin
      waddr[j*A +: A] = A'($urandom_range(0, amax));
      rsv_addr[j*A +: A] = A'($urandom_range(0, amax));
      wdata[j*X +: X] = $urandom;
    end
    for (int i = 0; i < NR; i++) raddr[i*A +: A] = A'($urandom_range(0, amax));
  endtask
  initial begin
    idle();
    raddr = '0;
    waddr = '0;
    rsv_addr = '0;
    wdata = '0;
    rst_n = 0;
    @(posedge clk);
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      m_regs[k] = '0;
      m_pend[k] = 0;
    end
    #1;
    rst_n = 1;
    // random traffic, then a one-cycle reset must wipe everything
    for (int c = 0; c < 20; c++) begin
      rnd_in(N - 1);
      flush = 0;
      step();
    end
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    for (int g = 0; g < N / NR; g++) begin
      for (int i = 0; i < NR; i++) raddr[i*A +: A] = A'(g * NR + i);
      mid();
      chk("rst_rdata", rdata[X-1:0] | rdata[X +: X] | rdata[2*X +: X] | rdata[3*X +: X], '0);
      chk("rst_rready", {28'b0, rready}, 32'hF);
      chk("rst_busy", busy, '0);
      fin();
    end
    // forwarding priority
    we = 2'b11;
    waddr = {5'd5, 5'd5};
    wdata = {32'hBBBB, 32'hAAAA};
    raddr = {5'd1, 5'd2, 5'd3, 5'd5};
    mid();
    chk("fwd_same", rdata[X-1:0], 32'hBBBB);
    fin();
    idle();
    mid();
    chk("fwd_next", rdata[X-1:0], 32'hBBBB);
    fin();
    // scoreboard stall and release
    rsv_en = 2'b01;
    rsv_addr = {5'd0, 5'd7};
    step();
    idle();
    raddr = {5'd0, 5'd0, 5'd7, 5'd0};
    mid();
    chk("stall_busy", {31'b0, busy[7]}, 32'd1);
    chk("stall_rready", {31'b0, rready[1]}, 32'd0);
    fin();
    we = 2'b01;
    waddr = {5'd0, 5'd7};
    wdata = {32'h0, 32'h1234};
    mid();
    chk("wb_rready", {31'b0, rready[1]}, 32'd1);
    chk("wb_rdata", rdata[X +: X], 32'h1234);
    fin();
    idle();
    mid();
    chk("wb_busy", {31'b0, busy[7]}, 32'd0);
    fin();
    // reserve and write-back collide on one edge
    we = 2'b01;
    waddr = {5'd0, 5'd9};
    wdata = {32'h0, 32'hCAFE};
    rsv_en = 2'b10;
    rsv_addr = {5'd9, 5'd0};
    step();
    idle();
    raddr = {5'd0, 5'd0, 5'd0, 5'd9};
    mid();
    chk("col_busy", {31'b0, busy[9]}, 32'd1);
    chk("col_rready", {31'b0, rready[0]}, 32'd0);
    chk("col_regs", rdata[X-1:0], 32'hCAFE);
    fin();
    // flush with a same-cycle reservation
    rsv_en = 2'b11;
    rsv_addr = {5'd4, 5'd3};
    step();
    rsv_en = 2'b01;
    rsv_addr = {5'd0, 5'd6};
    step();
    flush = 1;
    rsv_en = 2'b01;
    rsv_addr = {5'd0, 5'd4};
    step();
    idle();
    mid();
    chk("flush_busy", busy, 32'h10);
    fin();
    // x0 is hardwired
    we = 2'b01;
    waddr = '0;
    wdata = {32'h0, 32'hFFFF};
    rsv_en = 2'b01;
    rsv_addr = '0;
    raddr = '0;
    mid();
    chk("x0_rdata", rdata[X-1:0], '0);
    chk("x0_rready", {28'b0, rready}, 32'hF);
    fin();
    idle();
    mid();
    chk("x0_busy0", {31'b0, busy[0]}, 32'd0);
    chk("x0_after", rdata[X-1:0], '0);
    fin();
    // dense random traffic on few registers
    for (int c = 0; c < 400; c++) begin
      rnd_in(7);
      flush = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 63) != 0);
      step();
    end
    rst_n = 1;
    idle();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
